mux_sel_arbiter: RTL
====================

// Module: mux_sel_arbiter
// PURPOSE
//  Round-robin arbiter that shares the 10:1 one-bit select mux between up to
//  10 requesters. Drives the mux's 4-bit binary select code plus a one-hot
//  grant. Selects code 4'hF when idle, which makes the mux output 1'b0.
//  Sits directly upstream of the mux select input.
// PARAMETERS
//  N_REQ     10  number of requesters, 1..10 (select codes 0..N_REQ-1)
//  SEL_W     4   select width; fixed to match the mux select
//  MAX_HOLD  16  grant tenure limit in cycles, >=2 (used only with MUX_ARB_TIMEOUT_EN)
// PORTS
//  clk    in   1      single clock, rising edge
//  rst    in   1      synchronous, active-high reset
//  req    in   N_REQ  level request; bit k stays high while requester k wants the mux
//  grant  out  N_REQ  one-hot owner; all zero when idle
//  sel    out  SEL_W  binary index of the owner; 4'hF when idle
//  valid  out  1      high while a grant is held
// BEHAVIOUR
//  - All outputs are registered. The next-owner pick is combinational.
//  - Reset values: grant=0, sel=4'hF, valid=0, state=IDLE, ptr=0, hold_cnt=0.
//  - Reset has priority over every other event. Asserting rst mid-grant drops
//    the grant at that edge.
//  - Pick rule: the first set bit of the candidate vector, searching from ptr
//    upward and wrapping from N_REQ-1 to 0.
//  - ptr is updated to (owner+1) mod N_REQ on every new grant.
//  - IDLE state: if |req, grant the picked index at the next edge, then go to
//    GRANT. Latency from req rising to grant/sel/valid is 1 cycle.
//  - GRANT state, owner's req still high: hold grant, sel and valid unchanged.
//  - GRANT state, owner's req low: handover happens at the same edge.
//    - Candidates are the current req with the owner bit masked.
//    - If any candidate exists, the new owner is granted at that edge. There
//      is no idle cycle between owners.
//    - Otherwise go to IDLE, with grant=0, sel=4'hF, valid=0.
//  - Simultaneous events: a req bit rising in the same cycle the owner drops
//    is a valid candidate.
//  - req bits that drop before being granted are never granted.
//  - Invariants: grant is always one-hot or zero. sel always equals the index
//    of grant, or 4'hF when idle. valid == |grant.
// CONFIGURATION
//  MUX_ARB_TIMEOUT_EN defined:
//  - hold_cnt counts GRANT cycles and clears on every new grant.
//  - When hold_cnt==MAX_HOLD-1 and a candidate exists (owner masked), force a
//    handover to that candidate at that edge. The owner loses the grant even
//    though its req is high.
//  - If no candidate exists, keep the owner and clear hold_cnt.
//  MUX_ARB_TIMEOUT_EN undefined:
//  - hold_cnt and the MAX_HOLD logic are not built.
//  - The owner keeps the grant indefinitely while its req stays high.
// STRUCTURE
//  Shared package mux_arb_pkg:
//  - state enum {IDLE, GRANT}
//  - SEL_IDLE = 4'hF
//  - SEL_W
//  - onehot-to-index function
//  Sub-module rr_pick: combinational round-robin picker.
//  - inputs: cand[N_REQ], ptr
//  - outputs: any, idx[SEL_W]
//  - one instance, used for both the IDLE pick and handover.
// TESTING
//  1 rst held 2 cycles, req=10'h3FF -> grant=0, sel=4'hF, valid=0 throughout;
//    after release -> grant to index 0.
//  2 req[3] rises at cycle 0 -> cycle 1 grant=10'b0000001000, sel=3, valid=1;
//    req[3] drops at cycle 5 -> cycle 6 sel=4'hF, valid=0.
//  3 all 10 reqs high; each owner drops its req after 2 granted cycles and
//    re-raises it next cycle -> sel sequence 0,1,...,9,0 with no idle cycles.
//  4 owner 9 drops its req with req[5] and req[0] pending -> next grant is 0
//    (wrap), then 5.
//  5 MUX_ARB_TIMEOUT_EN, MAX_HOLD=4, req[2] and req[7] held high -> sel
//    alternates 2 for 4 cycles, then 7 for 4 cycles.
//    Without the macro -> sel=2 forever.
//    With the macro and only req[2] high -> sel=2 forever.
//  6 owner 4 holding; rst pulsed for 1 cycle -> next edge grant=0, sel=4'hF;
//    with req[4] and req[6] still high -> grant to 4 (ptr reset to 0).

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the mux select arbiter.
package mux_arb_pkg;

    localparam int unsigned SEL_W = 4;
    localparam logic [SEL_W-1:0] SEL_IDLE = 4'hF;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Binary index of the set bit in a one-hot vector (up to 16 requesters).
    function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [15:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) idx = idx | SEL_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between requesters and the mux select arbiter.
interface mux_sel_arbiter_if
    import mux_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 10
) ();

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic [SEL_W-1:0] sel;
    logic             valid;

    modport master (
        input  req,
        output grant,
        output sel,
        output valid
    );

    modport slave (
        output req,
        input  grant,
        input  sel,
        input  valid
    );

endinterface

// File: rtl/mux_sel_arbiter_rr_pick.sv
// Combinational round-robin picker: first set candidate at or above ptr, wrapping.
module rr_pick
    import mux_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 10
) (
    input  logic [N_REQ-1:0] cand,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N_REQ);

    // Walk from the farthest offset down so the nearest hit wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            logic [SEL_W:0]   pos;
            logic [SEL_W-1:0] k;
            pos = {1'b0, ptr} + (SEL_W+1)'(i);
            if (pos >= N_EXT) pos = pos - N_EXT;
            k = SEL_W'(pos);
            if (cand[k]) begin
                any = 1'b1;
                idx = k;
            end
        end
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin owner of the 10:1 mux select; drives one-hot grant and binary sel.
// Define MUX_ARB_TIMEOUT_EN to force handover after MAX_HOLD granted cycles.
module mux_sel_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned N_REQ    = 10,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                clk,
    input  logic                rst,
    mux_sel_arbiter_if.master   bus
);

    if (N_REQ < 1 || N_REQ > 10) begin : g_n_req_chk
        $error("N_REQ must be within 1..10");
    end
    if (MAX_HOLD < 2) begin : g_max_hold_chk
        $error("MAX_HOLD must be at least 2");
    end

    state_t           state;
    logic [N_REQ-1:0] grant_r;
    logic [SEL_W-1:0] sel_r;
    logic             valid_r;
    logic [SEL_W-1:0] ptr;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] cand_c;
    logic             owner_hold_c;
    logic             timeout_c;
    logic             any_c;
    logic [SEL_W-1:0] idx_c;
    logic [SEL_W-1:0] next_ptr_c;
    logic             take_c;
    logic             drop_c;

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int unsigned HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    logic [HOLD_W-1:0] hold_cnt;
`endif

    assign req = bus.req;

    // The owner is excluded from candidacy while in GRANT.
    always_comb begin
        cand_c       = (state == GRANT) ? (req & ~grant_r) : req;
        owner_hold_c = |(req & grant_r);
`ifdef MUX_ARB_TIMEOUT_EN
        timeout_c    = (state == GRANT) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
`else
        timeout_c    = 1'b0;
`endif
        next_ptr_c   = (idx_c == SEL_W'(N_REQ - 1)) ? '0 : SEL_W'(idx_c + 1'b1);
        take_c       = 1'b0;
        drop_c       = 1'b0;
        unique case (state)
            IDLE:  take_c = any_c;
            GRANT: begin
                take_c = any_c && (!owner_hold_c || timeout_c);
                drop_c = !any_c && !owner_hold_c;
            end
            default: ;
        endcase
    end

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .cand (cand_c),
        .ptr  (ptr),
        .any  (any_c),
        .idx  (idx_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant_r <= '0;
            sel_r   <= SEL_IDLE;
            valid_r <= 1'b0;
            ptr     <= '0;
`ifdef MUX_ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
        end else if (take_c) begin
            state   <= GRANT;
            grant_r <= N_REQ'(1) << idx_c;
            sel_r   <= idx_c;
            valid_r <= 1'b1;
            ptr     <= next_ptr_c;
`ifdef MUX_ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
        end else if (drop_c) begin
            state   <= IDLE;
            grant_r <= '0;
            sel_r   <= SEL_IDLE;
            valid_r <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
        end else begin
`ifdef MUX_ARB_TIMEOUT_EN
            // Lone owner at the tenure limit keeps the grant with a fresh count.
            if (state == GRANT) begin
                hold_cnt <= timeout_c ? '0 : HOLD_W'(hold_cnt + 1'b1);
            end
`endif
        end
    end

    assign bus.grant = grant_r;
    assign bus.sel   = sel_r;
    assign bus.valid = valid_r;

endmodule
